// File: rtl/adder_share_ctrl.sv
// Nibble-serial wide adder sequencer that shares one external 4-bit adder slice
// between two round-robin requesters and returns tagged results on a valid/ready port.
module adder_share_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req0_valid,
    input  logic [4*NIBBLES-1:0]   req0_a,
    input  logic [4*NIBBLES-1:0]   req0_b,
    input  logic                   req0_cin,
    output logic                   req0_ready,
    input  logic                   req1_valid,
    input  logic [4*NIBBLES-1:0]   req1_a,
    input  logic [4*NIBBLES-1:0]   req1_b,
    input  logic                   req1_cin,
    output logic                   req1_ready,
    output logic [3:0]             add_a,
    output logic [3:0]             add_b,
    output logic                   add_cin,
    input  logic [3:0]             add_s,
    input  logic                   add_cout,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic                   rsp_id,
    output logic [4*NIBBLES-1:0]   rsp_sum,
    output logic                   rsp_cout
);

    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);
    localparam logic [IW-1:0] IDX_ONE  = IW'(1);
    localparam logic [IW-1:0] IDX_ZERO = IW'(0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [IW-1:0]   r_idx;
    logic            r_carry;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic            r_cin;
    logic            r_id;
    logic            r_last;
    logic [W-1:0]    r_sum;
    logic            r_armed;

    logic            w_any_valid;
    logic            w_grant;
    logic            w_accept;
    logic            w_run;
    logic            w_done;
    logic [W-1:0]    w_a_shift;
    logic [W-1:0]    w_b_shift;

    // Round-robin: a lone requester wins; with both pending the one not served last wins.
    // r_armed keeps the first cycle after reset quiet.
    assign w_any_valid = req0_valid | req1_valid;
    assign w_grant     = (req0_valid & req1_valid) ? ~r_last : req1_valid;
    assign w_accept    = rst_n & r_armed & (r_state == S_IDLE) & w_any_valid;
    assign w_run       = rst_n & (r_state == S_RUN);
    assign w_done      = rst_n & (r_state == S_DONE);
    assign w_a_shift   = r_a >> {r_idx, 2'b00};
    assign w_b_shift   = r_b >> {r_idx, 2'b00};

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_RUN;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RUN: begin
                if (r_idx == LAST_IDX) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_RUN;
                end
            end
            S_DONE: begin
                if (rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_DONE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Operand capture, nibble index, carry chain and sum accumulation
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idx   <= IDX_ZERO;
            r_carry <= 1'b0;
            r_a     <= {W{1'b0}};
            r_b     <= {W{1'b0}};
            r_cin   <= 1'b0;
            r_id    <= 1'b0;
            r_last  <= 1'b1;
            r_sum   <= {W{1'b0}};
            r_armed <= 1'b0;
        end else begin
            r_armed <= 1'b1;
            if (w_accept) begin
                r_a     <= w_grant ? req1_a : req0_a;
                r_b     <= w_grant ? req1_b : req0_b;
                r_cin   <= w_grant ? req1_cin : req0_cin;
                r_id    <= w_grant;
                r_last  <= w_grant;
                r_idx   <= IDX_ZERO;
                r_carry <= 1'b0;
                r_sum   <= {W{1'b0}};
            end else if (r_state == S_RUN) begin
                r_sum[{r_idx, 2'b00} +: 4] <= add_s;
                r_carry <= add_cout;
                if (r_idx != LAST_IDX) begin
                    r_idx <= r_idx + IDX_ONE;
                end else begin
                    r_idx <= r_idx;
                end
            end else begin
                r_idx <= r_idx;
            end
        end
    end

    // Output decode: requester readies, adder slice drive, response port
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        add_a      = 4'd0;
        add_b      = 4'd0;
        add_cin    = 1'b0;
        rsp_valid  = 1'b0;
        rsp_id     = 1'b0;
        rsp_sum    = {W{1'b0}};
        rsp_cout   = 1'b0;
        if (w_accept) begin
            req0_ready = ~w_grant;
            req1_ready = w_grant;
        end else begin
            req0_ready = 1'b0;
            req1_ready = 1'b0;
        end
        if (w_run) begin
            add_a   = w_a_shift[3:0];
            add_b   = w_b_shift[3:0];
            add_cin = (r_idx == IDX_ZERO) ? r_cin : r_carry;
        end else begin
            add_a   = 4'd0;
            add_b   = 4'd0;
            add_cin = 1'b0;
        end
        if (w_done) begin
            rsp_valid = 1'b1;
            rsp_id    = r_id;
            rsp_sum   = r_sum;
            rsp_cout  = r_carry;
        end else begin
            rsp_valid = 1'b0;
            rsp_id    = 1'b0;
            rsp_sum   = {W{1'b0}};
            rsp_cout  = 1'b0;
        end
    end

endmodule

// File: doc/adder_share_ctrl.md
Name: adder_share_ctrl

Overview:
- Sequencer/arbiter that shares one external 4-bit ripple adder slice (a[3:0], b[3:0], cin -> s[3:0], cout) between two requesters.
- Each request is a wide add of 4*NIBBLES bits. The block performs it nibble-serially over NIBBLES cycles and chains the carry through a register.
- Returns the wide sum on a valid/ready response port tagged with the requester ID.
- Sits between the datapath adder slice and its client blocks.

Parameters:
- NIBBLES, 4, number of 4-bit slices per operation; operand width W = 4*NIBBLES (minimum 2).

Ports:
- clk  in  1  single system clock; all state on rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on rising clk.
- req0_valid  in  1  requester 0 has an operation pending.
- req0_a  in  W  requester 0 operand A.
- req0_b  in  W  requester 0 operand B.
- req0_cin  in  1  requester 0 carry-in.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req1_valid, req1_a, req1_b, req1_cin, req1_ready  same as requester 0, for requester 1.
- add_a  out  4  nibble A driven to the adder slice.
- add_b  out  4  nibble B driven to the adder slice.
- add_cin  out  1  carry-in driven to the adder slice.
- add_s  in  4  adder slice sum; combinational, valid in the same cycle.
- add_cout  in  1  adder slice carry-out; combinational.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer takes the result.
- rsp_id  out  1  requester that issued the result.
- rsp_sum  out  W  wide sum.
- rsp_cout  out  1  final carry-out.

Behaviour:
- Reset: rst_n low at a rising edge -> state IDLE, idx=0, carry reg=0, operand/sum regs=0, rr pointer last=1 (req0 wins first). All outputs 0 while in reset and on the first cycle after.
- States: IDLE, RUN, DONE.
- IDLE arbitration:
  - If exactly one req valid, grant it.
  - If both valid, grant the one not equal to last.
  - reqX_ready = (state==IDLE) && grant==X, combinational; it is high for one cycle only.
  - On accept, latch a, b, cin and id, set last=id, idx=0, go RUN.
  - With no valid request, stay IDLE with both readies low.
- RUN:
  - add_a = A[4*idx+3:4*idx], add_b = B[same slice].
  - add_cin = latched cin when idx==0, otherwise the carry reg.
  - Each cycle: sum[4*idx+3:4*idx] <= add_s, carry <= add_cout, idx <= idx+1.
  - When idx==NIBBLES-1, go DONE instead of incrementing.
- Adder outputs: add_a, add_b and add_cin are 0 whenever state != RUN.
- DONE:
  - rsp_valid=1; rsp_sum = sum reg, rsp_cout = carry reg, rsp_id = latched id.
  - All rsp_* stay stable while rsp_ready=0.
  - On rsp_ready=1, go IDLE next cycle. No request is accepted in the same cycle as the response handshake.
- Latency: accept at cycle T, RUN in T+1..T+NIBBLES, rsp_valid first high at T+NIBBLES+1. Minimum spacing between accepts is NIBBLES+2 cycles.
- Request inputs are ignored outside IDLE. A requester keeps valid high until it sees ready.
- Arithmetic: {rsp_cout, rsp_sum} = A + B + cin, modulo 2^(W+1). Carry ripples across nibbles through the carry reg only.
- Reset mid-operation (RUN or DONE): the operation is discarded and no response is produced; state returns to reset values.
- A request withdrawn (valid dropped) before grant is never serviced.

Test Plan:
1. Reset: hold rst_n=0 for 2 cycles with both req valid -> req*_ready=0, rsp_valid=0, add_*=0. After release, req0 is granted first.
2. Single req0: a=0x1234, b=0x0FFF, cin=0 -> rsp_valid 5 cycles after accept, rsp_sum=0x2233, rsp_cout=0, rsp_id=0. add_a sequence is 4,3,2,1.
3. Carry chain (req1): a=0xFFFF, b=0x0001, cin=0 -> rsp_sum=0x0000, rsp_cout=1. Then a=0xFFFF, b=0x0000, cin=1 -> rsp_sum=0x0000, rsp_cout=1, with add_cin=1 on all four RUN cycles.
4. Contention: both valid continuously -> grants alternate 0,1,0,1. Each rsp_id matches its grant and each result is correct.
5. Backpressure: rsp_ready=0 for 3 cycles in DONE -> rsp_* unchanged, req*_ready=0. Setting rsp_ready=1 produces the handshake, and the next accept comes one cycle later.
6. Reset at the second RUN cycle -> no rsp_valid pulse. A fresh req0 a=0x0001, b=0x0001 then yields rsp_sum=0x0002.
